// File: rtl/cache_line_arbiter_if.sv
// Cacheline miss-port bundle between the I/D caches, the arbiter and the cacheline adaptor.
// The arbiter uses the slave modport; the caches and adaptor side use master.
interface cache_line_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [15:0]       contention_cnt;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address,
           pmem_wdata, contention_cnt
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_address,
           pmem_wdata, contention_cnt
  );
endinterface

// File: rtl/cache_line_arbiter.sv
// Serialises I-cache and D-cache line transactions onto one physical-memory port,
// round-robin on contention, with a saturating contention counter.
module cache_line_arbiter #(
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input logic                 clk,
  input logic                 rst,
  cache_line_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_grant_d;
  logic              r_mask_i;
  logic              r_mask_d;
  logic              r_is_write;
  logic [15:0]       r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;

  logic w_i_req;
  logic w_d_req;
  logic w_grant_i;
  logic w_grant_d;
  logic w_pmem_read;
  logic w_pmem_write;
  logic w_i_resp;
  logic w_d_resp;

  // A requester just served is masked for one IDLE cycle so its lingering request line is not re-granted.
  assign w_i_req   = bus.i_read & ~r_mask_i;
  assign w_d_req   = (bus.d_read | bus.d_write) & ~r_mask_d;
  assign w_grant_i = w_i_req & (~w_d_req | r_last_grant_d);
  assign w_grant_d = w_d_req & (~w_i_req | ~r_last_grant_d);

  always_comb begin
    w_next_state = r_state;
    w_pmem_read  = 1'b0;
    w_pmem_write = 1'b0;
    w_i_resp     = 1'b0;
    w_d_resp     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_i)      w_next_state = I_BUSY;
        else if (w_grant_d) w_next_state = D_BUSY;
      end
      I_BUSY: begin
        w_pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          w_i_resp     = 1'b1;
          w_next_state = IDLE;
        end
      end
      D_BUSY: begin
        w_pmem_read  = ~r_is_write;
        w_pmem_write = r_is_write;
        if (bus.pmem_resp) begin
          w_d_resp     = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_last_grant_d <= 1'b0;
      r_mask_i       <= 1'b0;
      r_mask_d       <= 1'b0;
      r_is_write     <= 1'b0;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        r_mask_i <= 1'b0;
        r_mask_d <= 1'b0;
        if (w_i_req && w_d_req && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        if (w_grant_i) begin
          r_addr     <= {bus.i_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          r_is_write <= 1'b0;
        end else if (w_grant_d) begin
          r_addr     <= {bus.d_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          r_is_write <= bus.d_write;
          r_wdata    <= bus.d_wdata;
        end
      end else if (bus.pmem_resp) begin
        r_mask_i       <= (r_state == I_BUSY);
        r_mask_d       <= (r_state == D_BUSY);
        r_last_grant_d <= (r_state == D_BUSY);
      end
    end
  end

  assign bus.pmem_read      = w_pmem_read;
  assign bus.pmem_write     = w_pmem_write;
  assign bus.pmem_address   = r_addr;
  assign bus.pmem_wdata     = r_wdata;
  assign bus.i_resp         = w_i_resp;
  assign bus.d_resp         = w_d_resp;
  assign bus.i_rdata        = bus.pmem_rdata;
  assign bus.d_rdata        = bus.pmem_rdata;
  assign bus.contention_cnt = r_cnt;

endmodule
